// File: rtl/neuron_core_pkg.sv
// Shared types and constants for the neuron core Wishbone front-end.
package neuron_core_pkg;

    // Bus-side transfer sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    // Region codes driven on region_o and used to steer read data
    localparam logic [1:0] REG_SYN   = 2'd0;
    localparam logic [1:0] REG_PARAM = 2'd1;
    localparam logic [1:0] REG_SPIKE = 2'd2;
    localparam logic [1:0] REG_NONE  = 2'd3;

    // Default core placement in the user address space
    localparam logic [31:0] BASE_ADDR_DEF  = 32'h3000_0000;
    localparam logic [10:0] TOP_OFFSET_DEF = 11'h603;
    localparam logic [10:0] SPIKE_OFFSET   = 11'h600;

    // Priority select of the decoder outputs; out-of-range always wins
    function automatic logic [1:0] region_pick(
        input logic in_range,
        input logic syn_sel,
        input logic par_sel,
        input logic spk_sel
    );
        logic [1:0] region;
        if (!in_range) begin
            region = REG_NONE;
        end else if (syn_sel) begin
            region = REG_SYN;
        end else if (par_sel) begin
            region = REG_PARAM;
        end else if (spk_sel) begin
            region = REG_SPIKE;
        end else begin
            region = REG_NONE;
        end
        return region;
    endfunction

endpackage

// File: rtl/nc_rd_mux.sv
// Read-data select: picks the responding region's data, zero for no region.
module nc_rd_mux
    import neuron_core_pkg::*;
(
    input  logic [1:0]  region,
    input  logic [31:0] synap_rdata,
    input  logic [31:0] param_rdata,
    input  logic [31:0] spike_rdata,
    output logic [31:0] rdata
);

    // 4:1 select keyed on the registered region code
    always_comb begin
        rdata = 32'h0;
        case (region)
            REG_SYN:   rdata = synap_rdata;
            REG_PARAM: rdata = param_rdata;
            REG_SPIKE: rdata = spike_rdata;
            default:   rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/neuron_core_wb_slave.sv
// Wishbone classic slave for the neuron core: registers each request,
// converts decoder region selects into one-cycle access strobes,
// sequences read wait-states and returns a single-cycle acknowledge.
module neuron_core_wb_slave
    import neuron_core_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
    parameter logic [10:0] TOP_OFFSET = TOP_OFFSET_DEF,
    parameter int unsigned RD_LAT     = 1        // valid range 1..7
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] addr_o,
    input  logic        synap_matrix_i,
    input  logic        param_i,
    input  logic        spike_sel_i,
    input  logic [4:0]  param_num_i,
    output logic        wr_en_o,
    output logic        rd_en_o,
    output logic [1:0]  region_o,
    output logic [4:0]  param_num_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wsel_o,
    input  logic [31:0] synap_rdata_i,
    input  logic [31:0] param_rdata_i,
    input  logic [31:0] spike_rdata_i
);

    localparam logic [2:0] RD_LAT_CNT = 3'(RD_LAT);

    state_t      state_reg;
    logic [2:0]  cnt_reg;
    logic        we_reg;
    logic        in_range;
    logic [1:0]  region_next;
    logic [31:0] rdata_mux;

    // Range check on the latched address and region priority resolution
    always_comb begin
        in_range    = (addr_o[31:11] == BASE_ADDR[31:11]) &&
                      (addr_o[10:0] <= TOP_OFFSET);
        region_next = region_pick(in_range, synap_matrix_i, param_i, spike_sel_i);
    end

    nc_rd_mux u_rd_mux (
        .region      (region_o),
        .synap_rdata (synap_rdata_i),
        .param_rdata (param_rdata_i),
        .spike_rdata (spike_rdata_i),
        .rdata       (rdata_mux)
    );

    // Transfer state machine; all bus and core-side outputs registered here
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 3'd0;
            we_reg      <= 1'b0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= 32'h0;
            addr_o      <= 32'h0;
            wr_en_o     <= 1'b0;
            rd_en_o     <= 1'b0;
            region_o    <= REG_NONE;
            param_num_o <= 5'd0;
            wdata_o     <= 32'h0;
            wsel_o      <= 4'h0;
        end else begin
            // Strobes and ack are single-cycle pulses by default
            wr_en_o   <= 1'b0;
            rd_en_o   <= 1'b0;
            wbs_ack_o <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // The ack cycle itself never accepts, so a master that
                    // holds stb until it sees ack cannot be taken twice.
                    if (wbs_cyc_i && wbs_stb_i && !wbs_ack_o) begin
                        addr_o    <= wbs_adr_i;
                        we_reg    <= wbs_we_i;
                        wsel_o    <= wbs_sel_i;
                        wdata_o   <= wbs_dat_i;
                        state_reg <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    region_o    <= region_next;
                    param_num_o <= param_num_i;
                    if (we_reg) begin
                        wr_en_o   <= (region_next != REG_NONE);
                        state_reg <= ST_ACK;
                    end else begin
                        rd_en_o   <= (region_next != REG_NONE);
                        cnt_reg   <= RD_LAT_CNT;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!wbs_cyc_i) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                        if (cnt_reg == 3'd1) begin
                            wbs_dat_o <= rdata_mux;
                            state_reg <= ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    wbs_ack_o <= wbs_cyc_i;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_core_wb_slave.sv
// Directed bench for neuron_core_wb_slave: instance a uses the default read
// latency, instance b uses a read latency of 3; both share the bus inputs.
module tb_neuron_core_wb_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        syn, par, spk;
    logic [4:0]  pnum_in;
    logic [31:0] syn_rd, par_rd, spk_rd;

    logic        a_ack, a_wr, a_rd, b_ack, b_wr, b_rd;
    logic [31:0] a_dat, a_addr, a_wdata, b_dat, b_addr, b_wdata;
    logic [1:0]  a_region, b_region;
    logic [4:0]  a_pnum, b_pnum;
    logic [3:0]  a_wsel, b_wsel;

    neuron_core_wb_slave dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(a_ack), .wbs_dat_o(a_dat),
        .addr_o(a_addr), .synap_matrix_i(syn), .param_i(par), .spike_sel_i(spk),
        .param_num_i(pnum_in), .wr_en_o(a_wr), .rd_en_o(a_rd), .region_o(a_region),
        .param_num_o(a_pnum), .wdata_o(a_wdata), .wsel_o(a_wsel),
        .synap_rdata_i(syn_rd), .param_rdata_i(par_rd), .spike_rdata_i(spk_rd)
    );

    neuron_core_wb_slave #(.RD_LAT(3)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(b_ack), .wbs_dat_o(b_dat),
        .addr_o(b_addr), .synap_matrix_i(syn), .param_i(par), .spike_sel_i(spk),
        .param_num_i(pnum_in), .wr_en_o(b_wr), .rd_en_o(b_rd), .region_o(b_region),
        .param_num_o(b_pnum), .wdata_o(b_wdata), .wsel_o(b_wsel),
        .synap_rdata_i(syn_rd), .param_rdata_i(par_rd), .spike_rdata_i(spk_rd)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Per-cycle record of one transfer; index k = cycle after edge N+k
    logic        a_ack_r[10], a_wr_r[10], a_rd_r[10], b_ack_r[10], b_rd_r[10];
    logic [31:0] a_dat_r[10], a_addr_r[10], a_wdata_r[10], b_dat_r[10];
    logic [1:0]  a_region_r[10], b_region_r[10];
    logic [3:0]  a_wsel_r[10];
    logic [4:0]  a_pnum_r[10];
    int          a_ack_n, a_wr_n, a_rd_n, b_ack_n, b_wr_n, b_rd_n;

    // One request with stb for a single edge; cyc drops from cycle drop_k,
    // reset pulses for the edge after cycle rst_k.
    task automatic run_xfer(input logic w, input logic [31:0] ad, input logic [31:0] dt,
                            input logic [3:0] sl, input int drop_k, input int rst_k);
        cyc = 1'b1; stb = 1'b1; we = w; adr = ad; dat = dt; sel = sl;
        a_ack_n = 0; a_wr_n = 0; a_rd_n = 0; b_ack_n = 0; b_wr_n = 0; b_rd_n = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            a_ack_r[k] = a_ack; a_wr_r[k] = a_wr; a_rd_r[k] = a_rd;
            a_dat_r[k] = a_dat; a_addr_r[k] = a_addr; a_wdata_r[k] = a_wdata;
            a_region_r[k] = a_region; a_wsel_r[k] = a_wsel; a_pnum_r[k] = a_pnum;
            b_ack_r[k] = b_ack; b_rd_r[k] = b_rd; b_dat_r[k] = b_dat; b_region_r[k] = b_region;
            a_ack_n += int'(a_ack); a_wr_n += int'(a_wr); a_rd_n += int'(a_rd);
            b_ack_n += int'(b_ack); b_wr_n += int'(b_wr); b_rd_n += int'(b_rd);
            stb = 1'b0;
            rst = (k == rst_k);
            if (k >= drop_k) cyc = 1'b0;
        end
        cyc = 1'b0; rst = 1'b0;
        $display("xfer we=%0b adr=%h dat=%h sel=%h | a: acks=%0d wr=%0d rd=%0d rdata=%h | b: acks=%0d rd=%0d rdata=%h",
                 w, ad, dt, sl, a_ack_n, a_wr_n, a_rd_n, a_dat_r[9], b_ack_n, b_rd_n, b_dat_r[9]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("reset applied");
        if ({a_ack, a_wr, a_rd} !== 3'b000) begin n_bad++; $display("FAIL rst_pulses: got %b want 000", {a_ack, a_wr, a_rd}); end
        n_cmp++;
        if ({a_dat, a_addr, a_wdata} !== 96'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", {a_dat, a_addr, a_wdata}); end
        n_cmp++;
        if ({a_wsel, a_pnum} !== 9'h0) begin n_bad++; $display("FAIL rst_sel_pnum: got %h want 0", {a_wsel, a_pnum}); end
        n_cmp++;
        if ({a_region, b_region} !== 4'hF) begin n_bad++; $display("FAIL rst_region: got %b want 1111", {a_region, b_region}); end
        n_cmp++;
        rst = 1'b0;
    endtask

    task automatic test_write();
        syn = 1'b1; par = 1'b1; spk = 1'b0;    // synapse must win over param
        run_xfer(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 99, 99);
        if (a_addr_r[1] !== 32'h3000_0010) begin n_bad++; $display("FAIL wr_addr: got %h want 30000010", a_addr_r[1]); end
        n_cmp++;
        if ({a_wdata_r[1], a_wsel_r[1]} !== {32'hDEAD_BEEF, 4'hF}) begin n_bad++; $display("FAIL wr_qual: got %h want deadbeeff", {a_wdata_r[1], a_wsel_r[1]}); end
        n_cmp++;
        if ({a_wr_r[0], a_wr_r[1], a_wr_r[2]} !== 3'b010) begin n_bad++; $display("FAIL wr_strobe_time: got %b want 010", {a_wr_r[0], a_wr_r[1], a_wr_r[2]}); end
        n_cmp++;
        if (a_wr_n !== 1 || a_rd_n !== 0) begin n_bad++; $display("FAIL wr_strobe_count: got wr=%0d rd=%0d want 1/0", a_wr_n, a_rd_n); end
        n_cmp++;
        if (a_region_r[1] !== 2'd0) begin n_bad++; $display("FAIL wr_region: got %0d want 0", a_region_r[1]); end
        n_cmp++;
        if (a_ack_r[2] !== 1'b1 || a_ack_n !== 1) begin n_bad++; $display("FAIL wr_ack: got ack2=%b n=%0d want 1/1", a_ack_r[2], a_ack_n); end
        n_cmp++;
        if (b_ack_r[2] !== 1'b1 || b_wr_n !== 1) begin n_bad++; $display("FAIL wr_ack_b: got ack2=%b wr=%0d want 1/1", b_ack_r[2], b_wr_n); end
        n_cmp++;
    endtask

    task automatic test_read_param();
        syn = 1'b0; par = 1'b1; spk = 1'b0; pnum_in = 5'd0; par_rd = 32'h1234_5678;
        run_xfer(1'b0, 32'h3000_0404, 32'h0, 4'hF, 99, 99);
        if (a_rd_r[1] !== 1'b1 || a_rd_n !== 1 || a_wr_n !== 0) begin n_bad++; $display("FAIL rdp_strobe: got rd1=%b rd=%0d wr=%0d want 1/1/0", a_rd_r[1], a_rd_n, a_wr_n); end
        n_cmp++;
        if (a_region_r[1] !== 2'd1) begin n_bad++; $display("FAIL rdp_region: got %0d want 1", a_region_r[1]); end
        n_cmp++;
        if (a_ack_r[3] !== 1'b1 || a_ack_n !== 1 || a_dat_r[3] !== 32'h1234_5678) begin n_bad++; $display("FAIL rdp_ack_data: got ack3=%b n=%0d dat=%h want 1/1/12345678", a_ack_r[3], a_ack_n, a_dat_r[3]); end
        n_cmp++;
        if (b_ack_r[5] !== 1'b1 || b_dat_r[5] !== 32'h1234_5678) begin n_bad++; $display("FAIL rdp_b: got ack5=%b dat=%h want 1/12345678", b_ack_r[5], b_dat_r[5]); end
        n_cmp++;
    endtask

    task automatic test_read_spike();
        syn = 1'b0; par = 1'b0; spk = 1'b1; spk_rd = 32'hA5A5_0001;
        run_xfer(1'b0, 32'h3000_0600, 32'h0, 4'hF, 99, 99);
        if (b_rd_r[1] !== 1'b1 || b_region_r[1] !== 2'd2) begin n_bad++; $display("FAIL rds_strobe: got rd1=%b region=%0d want 1/2", b_rd_r[1], b_region_r[1]); end
        n_cmp++;
        if (b_ack_r[4] !== 1'b0 || b_ack_r[5] !== 1'b1 || b_ack_n !== 1) begin n_bad++; $display("FAIL rds_ack_lat3: got ack4=%b ack5=%b n=%0d want 0/1/1", b_ack_r[4], b_ack_r[5], b_ack_n); end
        n_cmp++;
        if (b_dat_r[5] !== 32'hA5A5_0001) begin n_bad++; $display("FAIL rds_data_b: got %h want a5a50001", b_dat_r[5]); end
        n_cmp++;
        if (a_ack_r[3] !== 1'b1 || a_dat_r[3] !== 32'hA5A5_0001) begin n_bad++; $display("FAIL rds_a: got ack3=%b dat=%h want 1/a5a50001", a_ack_r[3], a_dat_r[3]); end
        n_cmp++;
    endtask

    task automatic test_range();
        // Decoder claims synapse, but the address is beyond the core window
        syn = 1'b1; par = 1'b0; spk = 1'b0;
        run_xfer(1'b0, 32'h3000_0800, 32'h0, 4'hF, 99, 99);
        if (a_rd_n + a_wr_n + b_rd_n + b_wr_n !== 0) begin n_bad++; $display("FAIL oor_strobes: got %0d want 0", a_rd_n + a_wr_n + b_rd_n + b_wr_n); end
        n_cmp++;
        if (a_region_r[1] !== 2'd3) begin n_bad++; $display("FAIL oor_region: got %0d want 3", a_region_r[1]); end
        n_cmp++;
        if (a_ack_r[3] !== 1'b1 || a_dat_r[3] !== 32'h0 || b_ack_r[5] !== 1'b1 || b_dat_r[5] !== 32'h0) begin n_bad++; $display("FAIL oor_read: got a=%b/%h b=%b/%h want 1/0 1/0", a_ack_r[3], a_dat_r[3], b_ack_r[5], b_dat_r[5]); end
        n_cmp++;
        // Last valid byte offset is still in range
        syn = 1'b0; spk = 1'b1; spk_rd = 32'hA5A5_0001;
        run_xfer(1'b0, 32'h3000_0603, 32'h0, 4'hF, 99, 99);
        if (a_region_r[1] !== 2'd2 || a_dat_r[3] !== 32'hA5A5_0001) begin n_bad++; $display("FAIL top_offset_read: got region=%0d dat=%h want 2/a5a50001", a_region_r[1], a_dat_r[3]); end
        n_cmp++;
        // One past the last offset: write acked and dropped
        run_xfer(1'b1, 32'h3000_0604, 32'h1111_2222, 4'hF, 99, 99);
        if (a_wr_n !== 0 || a_ack_r[2] !== 1'b1 || a_region_r[1] !== 2'd3) begin n_bad++; $display("FAIL past_top_write: got wr=%0d ack2=%b region=%0d want 0/1/3", a_wr_n, a_ack_r[2], a_region_r[1]); end
        n_cmp++;
        if (a_dat_r[3] !== 32'hA5A5_0001) begin n_bad++; $display("FAIL write_keeps_rdata: got %h want a5a50001", a_dat_r[3]); end
        n_cmp++;
    endtask

    task automatic test_abort();
        syn = 1'b0; par = 1'b1; spk = 1'b0; pnum_in = 5'd9; par_rd = 32'h55AA_55AA;
        run_xfer(1'b0, 32'h3000_0404, 32'h0, 4'hF, 1, 99);
        if (a_rd_r[1] !== 1'b1 || a_ack_n !== 0 || b_ack_n !== 0) begin n_bad++; $display("FAIL abort_ack: got rd1=%b a_acks=%0d b_acks=%0d want 1/0/0", a_rd_r[1], a_ack_n, b_ack_n); end
        n_cmp++;
        if (a_dat_r[9] !== 32'hA5A5_0001 || b_dat_r[9] !== 32'hA5A5_0001) begin n_bad++; $display("FAIL abort_data_kept: got a=%h b=%h want a5a50001", a_dat_r[9], b_dat_r[9]); end
        n_cmp++;
        run_xfer(1'b0, 32'h3000_0404, 32'h0, 4'hF, 99, 99);
        if (a_ack_r[3] !== 1'b1 || a_dat_r[3] !== 32'h55AA_55AA) begin n_bad++; $display("FAIL after_abort_read: got ack3=%b dat=%h want 1/55aa55aa", a_ack_r[3], a_dat_r[3]); end
        n_cmp++;
        if (a_pnum_r[1] !== 5'd9) begin n_bad++; $display("FAIL param_num_fwd: got %0d want 9", a_pnum_r[1]); end
        n_cmp++;
    endtask

    task automatic test_reset_in_ack();
        syn = 1'b1; par = 1'b0; spk = 1'b0;
        run_xfer(1'b1, 32'h3000_0010, 32'hCAFE_F00D, 4'h3, 99, 1);
        if (a_wr_r[1] !== 1'b1 || a_ack_n !== 0 || b_ack_n !== 0) begin n_bad++; $display("FAIL rst_ack_suppress: got wr1=%b a_acks=%0d b_acks=%0d want 1/0/0", a_wr_r[1], a_ack_n, b_ack_n); end
        n_cmp++;
        if ({a_addr_r[2], a_wdata_r[2], a_dat_r[2]} !== 96'h0) begin n_bad++; $display("FAIL rst_mid_data: got %h want 0", {a_addr_r[2], a_wdata_r[2], a_dat_r[2]}); end
        n_cmp++;
        if ({a_wsel_r[2], a_pnum_r[2], a_region_r[2]} !== {4'h0, 5'd0, 2'd3}) begin n_bad++; $display("FAIL rst_mid_qual: got %h want 003", {a_wsel_r[2], a_pnum_r[2], a_region_r[2]}); end
        n_cmp++;
        run_xfer(1'b1, 32'h3000_0020, 32'h0BAD_CAFE, 4'h1, 99, 99);
        if (a_wr_r[1] !== 1'b1 || a_ack_r[2] !== 1'b1 || a_addr_r[1] !== 32'h3000_0020) begin n_bad++; $display("FAIL after_rst_write: got wr1=%b ack2=%b addr=%h want 1/1/30000020", a_wr_r[1], a_ack_r[2], a_addr_r[1]); end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        int lat;
        int wrn;
        logic got;
        syn = 1'b1; par = 1'b0; spk = 1'b0;
        cyc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stb = 1'b1; we = 1'b1; adr = 32'h3000_0100 + 32'(i * 4); dat = 32'(i + 1); sel = 4'hF;
            lat = 0; wrn = 0; got = 1'b0;
            while (!got && lat < 8) begin
                @(posedge clk);
                @(negedge clk);
                lat++;
                wrn += int'(a_wr);
                if (a_ack) got = 1'b1;
            end
            stb = 1'b0;
            $display("b2b write %0d adr=%h latency=%0d wr_pulses=%0d", i, adr, lat, wrn);
            if (lat !== 3 || wrn !== 1) begin n_bad++; $display("FAIL b2b_%0d: got lat=%0d wr=%0d want 3/1", i, lat, wrn); end
            n_cmp++;
            @(posedge clk);
            @(negedge clk);
            if (a_ack !== 1'b0 || a_wr !== 1'b0) begin n_bad++; $display("FAIL b2b_gap_%0d: got ack=%b wr=%b want 0/0", i, a_ack, a_wr); end
            n_cmp++;
        end
        cyc = 1'b0;
        if (a_addr !== 32'h3000_0108 || a_wdata !== 32'd3) begin n_bad++; $display("FAIL b2b_last: got addr=%h data=%h want 30000108/3", a_addr, a_wdata); end
        n_cmp++;
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; dat = 32'h0; syn = 1'b0; par = 1'b0; spk = 1'b0;
        pnum_in = 5'd0; syn_rd = 32'h5151_5151; par_rd = 32'h0; spk_rd = 32'h0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read_param();
        test_read_spike();
        test_range();
        test_abort();
        test_reset_in_ack();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/neuron_core_wb_slave.md
# neuron_core_wb_slave

Wishbone classic slave front-end for the 256x256 neuron core in the Caravel user area. Registers each bus request, forwards the word address to the address slice decoder, and turns the returned region selects into single-cycle write/read strobes for the synapse matrix, the parameter bank, and the spike-out register. Sequences read wait-states, muxes read data, and generates `wbs_ack_o`.

## Interface
- `BASE_ADDR`, 32'h3000_0000: core base address.
- `TOP_OFFSET`, 11'h603: highest valid byte offset; spike_out ends at 0x3000_0603.
- `RD_LAT`, 1: cycles from `rd_en_o` until read data is valid at the `*_rdata_i` inputs; range 1..7.
- `wb_clk_i` in 1: the block's only clock.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone cycle, strobe and write-enable.
- `wbs_sel_i` in 4: byte lanes.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: transfer acknowledge.
- `wbs_dat_o` out 32: read data.
- `addr_o` out 32: registered request address, fed to the slice decoder.
- `synap_matrix_i`, `param_i`, `spike_sel_i` in 1 each: region selects returned by the decoder.
- `param_num_i` in 5: parameter index returned by the decoder.
- `wr_en_o`, `rd_en_o` out 1 each: one-cycle access strobes.
- `region_o` out 2: 0 = synapse, 1 = param, 2 = spike, 3 = none.
- `param_num_o` out 5, `wdata_o` out 32, `wsel_o` out 4: access qualifiers, valid while a strobe is high.
- `synap_rdata_i`, `param_rdata_i`, `spike_rdata_i` in 32 each: read data per region.

## Operation
- The state machine has four states: IDLE, ACCESS, WAIT, ACK.
- IDLE: when `cyc & stb` is high, latch `adr`, `we`, `sel` and `dat` into `addr_o`, `wdata_o` and `wsel_o`, then go to ACCESS.
- ACCESS: sample the decoder selects and compute `region_o` by priority: synapse, then param, then spike.
- An address is out of range when `adr[31:11] != BASE_ADDR[31:11]` or `adr[10:0] > TOP_OFFSET`. An out-of-range address forces region 3.
- ACCESS with a write: pulse `wr_en_o` if the region is not 3, then go to ACK.
- ACCESS with a read: pulse `rd_en_o` if the region is not 3, load the wait counter with `RD_LAT`, then go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0, capture the selected `*_rdata_i` into `wbs_dat_o` and go to ACK. Region 3 captures 32'h0.
- ACK: assert `wbs_ack_o` for exactly one cycle, then go to IDLE.
- Region 3 writes are acked and dropped; region 3 reads are acked with 0. No error signalling.
- `wbs_dat_o` holds its value until the next read capture; writes do not change it.
- The `wsel_o` byte mask is forwarded unchanged. Byte merging is done downstream.
- Abort: if `cyc` is low in WAIT or ACK, go to IDLE with no ack and no data capture. A write strobe that has already been issued stands.
- In IDLE, `stb` without `cyc` is ignored.

## Timing
- Reset values: `wbs_ack_o`, `wr_en_o` and `rd_en_o` are 0. `wbs_dat_o`, `addr_o`, `wdata_o`, `wsel_o` and `param_num_o` are 0. `region_o` is 3 and the state is IDLE.
- Write: request sampled at edge N, `wr_en_o` high in cycle N+1, ack high in cycle N+2. Latency is 2.
- Read: request sampled at edge N, `rd_en_o` high in cycle N+1, data captured at edge N+1+`RD_LAT`, ack high in the following cycle. Latency is `RD_LAT`+2, i.e. 3 at the default.
- Back-to-back: a new request is accepted in the cycle after ACK. With a compliant master, `stb` is already low in that cycle, so there is no double accept.
- Strobes are never high in two consecutive cycles.
- A reset asserted mid-transfer takes effect at the next edge: return to IDLE with no ack.
- Every output is registered.

## Structure
- `neuron_core_pkg` holds:
  - the state enumeration;
  - the region codes (`REG_SYN`, `REG_PARAM`, `REG_SPIKE`, `REG_NONE`);
  - `BASE_ADDR` and `TOP_OFFSET` defaults;
  - the spike_out offset 11'h600.
- One sub-module, `nc_rd_mux`: a combinational 4:1 read-data select keyed on `region_o`, with region 3 producing 0.
- The wait counter is 3 bits and lives inline.

## Test plan
- Write 0x3000_0010 with data 0xDEADBEEF and sel 4'hF: `addr_o` = 0x3000_0010, `wr_en_o` pulses one cycle in cycle N+1 with region 0; ack in cycle N+2.
- Read 0x3000_0404 with `param_num_i` = 0 and `param_rdata_i` = 0x12345678: `rd_en_o` in cycle N+1 with region 1; `wbs_dat_o` = 0x12345678 and ack in cycle N+3.
- Read 0x3000_0600 with `spike_rdata_i` = 0xA5A5_0001 and `RD_LAT` = 3: ack in cycle N+5 with data 0xA5A5_0001.
- Read 0x3000_0800 (out of range): no strobes; ack in cycle N+3 with data 0.
- Read, then drop `cyc` in the WAIT cycle: no ack; `wbs_dat_o` keeps its old value; the state is IDLE next cycle.
- Assert `wb_rst_i` in the ACK cycle: ack low the next cycle and all outputs at reset values; the next request completes normally.
